// File: rtl/mdr_read_ctrl.sv
// mdr_read_ctrl: read-side controller for the 32-bit memory data register (q).
// Accepts a read request from the control unit and fetches one word from RAM
// over a req/ack handshake. Then it latches the word into q and pulses done.
// Optional build macro: TIMEOUT_EN. When it is defined, a read that waits TIMEOUT
// REQ edges without an ack is abandoned, and done and err pulse together.
//
// Memory handshake: mem_rd is a level request. It rises on the edge that accepts
// rd_start. It stays high, with mem_addr stable, until the first rising edge that
// sees mem_ack=1, or until a timeout. mem_ack is only honoured while mem_rd=1,
// and mem_data is captured on that same edge.
// The FSM state is held in the internal signal "state" so checkers can bind to it.
module mdr_read_ctrl #(
  parameter int AW      = 9,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          rd_start,
  input  logic [AW-1:0] addr,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] q,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] q_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic          mem_rd_nxt;
  logic          busy_nxt;
  logic          done_nxt;
  logic          err_nxt;

`ifdef TIMEOUT_EN
  localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
`endif

  // Register all outputs and the state; clr dominates every other input
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      q        <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      state    <= state_nxt;
      q        <= q_nxt;
      mem_addr <= mem_addr_nxt;
      mem_rd   <= mem_rd_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
`ifdef TIMEOUT_EN
      cnt      <= cnt_nxt;
`endif
    end
  end

  // Next-state and next-output decode; done/err are single-cycle pulses by default
  always_comb begin
    state_nxt    = state;
    q_nxt        = q;
    mem_addr_nxt = mem_addr;
    mem_rd_nxt   = mem_rd;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
`ifdef TIMEOUT_EN
    cnt_nxt      = cnt;
`endif
    case (state)
      S_IDLE: begin
        // mem_ack is ignored here; only a new request moves us on
        if (rd_start) begin
          mem_addr_nxt = addr;
          mem_rd_nxt   = 1'b1;
          busy_nxt     = 1'b1;
          state_nxt    = S_REQ;
`ifdef TIMEOUT_EN
          cnt_nxt      = '0;
`endif
        end
      end
      S_REQ: begin
        // An ack on the same edge as the timeout still counts as a normal read
        if (mem_ack) begin
          q_nxt      = mem_data;
          mem_rd_nxt = 1'b0;
          done_nxt   = 1'b1;
          state_nxt  = S_DONE;
        end
`ifdef TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          mem_rd_nxt = 1'b0;
          done_nxt   = 1'b1;
          err_nxt    = 1'b1;
          state_nxt  = S_DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      S_DONE: begin
        // One recovery cycle; a rd_start seen here waits for IDLE
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mdr_read_ctrl.sv
// tb_mdr_read_ctrl: directed checks with hand-computed values, then randomized
// traffic compared every cycle against a transaction-level reference model.
// Honours TIMEOUT_EN the same way as the design (TIMEOUT overridden to 4).
module tb_mdr_read_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr;
  logic          rd_start;
  logic [AW-1:0] addr;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_ack;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] q;
  logic          busy;
  logic          done;
  logic          err;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] exp_q[$];

  mdr_read_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .clr      (clr),
    .rd_start (rd_start),
    .addr     (addr),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .q        (q),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Transaction view: idle when not busy, waiting while the request is up,
  // finishing for the one busy cycle after the request drops.
  logic [DW-1:0] m_q;
  logic [AW-1:0] m_addr;
  logic          m_rd, m_busy, m_done, m_err;
  int            m_wait;

  always @(posedge clk) begin
    if (clr) begin
      m_q = '0; m_addr = '0; m_rd = 1'b0; m_busy = 1'b0;
      m_done = 1'b0; m_err = 1'b0; m_wait = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      m_done = 1'b0; m_err = 1'b0;
      if (rd_start) begin
        m_addr = addr; m_rd = 1'b1; m_busy = 1'b1; m_wait = 0;
      end
    end else if (m_rd) begin
      if (mem_ack) begin
        m_q = mem_data; m_rd = 1'b0; m_done = 1'b1;
        exp_q.push_back(mem_data);
      end
`ifdef TIMEOUT_EN
      else if (m_wait + 1 == TO) begin
        m_rd = 1'b0; m_done = 1'b1; m_err = 1'b1;
      end
`endif
      else begin
        m_wait++;
      end
    end else begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("q",        q,        m_q);
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_rd",   32'(mem_rd),   32'(m_rd));
      chk("busy",     32'(busy),     32'(m_busy));
      chk("done",     32'(done),     32'(m_done));
      chk("err",      32'(err),      32'(m_err));
      if (done && !err) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_empty: done seen, no expected word queued (t=%0t)", $time);
        end else begin
          chk("sb_q", q, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int dn;
    clr = 1'b1; rd_start = 1'b0; addr = '0; mem_ack = 1'b0; mem_data = '0;

    // Reset from unknown state
    tick(); tick();
    chk("rst_q",    q,              32'h0);
    chk("rst_rd",   32'(mem_rd),    32'h0);
    chk("rst_busy", 32'(busy),      32'h0);
    chk("rst_done", 32'(done),      32'h0);
    chk("rst_err",  32'(err),       32'h0);
    chk_en = 1'b1;
    clr = 1'b0;

    // Single read with ack already waiting
    rd_start = 1'b1; addr = 9'h05C; mem_ack = 1'b1; mem_data = 32'h0000_005C;
    tick();
    chk("t2_addr", 32'(mem_addr), 32'h05C);
    chk("t2_rd",   32'(mem_rd),   32'h1);
    chk("t2_nd",   32'(done),     32'h0);
    rd_start = 1'b0;
    tick();
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_q",    q,         32'h0000_005C);
    tick();
    chk("t2_busy", 32'(busy), 32'h0);
    mem_ack = 1'b0;

    // Delayed ack, rd_start pulsed while busy
    rd_start = 1'b1; addr = 9'h010; mem_data = 32'h0000_FB02;
    tick();
    chk("t3_rd1",  32'(mem_rd),   32'h1);
    chk("t3_addr", 32'(mem_addr), 32'h010);
    chk("t3_qold", q,             32'h0000_005C);
    tick();
    chk("t3_rd2",  32'(mem_rd),   32'h1);
    chk("t3_qold2", q,            32'h0000_005C);
    rd_start = 1'b0;
    tick();
    chk("t3_rd3",  32'(mem_rd),   32'h1);
    mem_ack = 1'b1;
    tick();
    chk("t3_done", 32'(done),   32'h1);
    chk("t3_q",    q,           32'h0000_FB02);
    chk("t3_rd0",  32'(mem_rd), 32'h0);
    mem_ack = 1'b0; rd_start = 1'b1;
    tick();
    chk("t3_busy", 32'(busy),   32'h0);
    chk("t3_ign",  32'(mem_rd), 32'h0);
    rd_start = 1'b0;
    tick();
    chk("t3_ign2", 32'(mem_rd), 32'h0);

    // No ack: timeout when enabled, indefinite wait otherwise
    rd_start = 1'b1; addr = 9'h1FF;
    tick();
    rd_start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
`ifdef TIMEOUT_EN
      if (i < 4) begin
        chk("t5_rd",  32'(mem_rd), 32'h1);
        chk("t5_err", 32'(err),    32'h0);
      end else begin
        chk("t5_to_done", 32'(done),   32'h1);
        chk("t5_to_err",  32'(err),    32'h1);
        chk("t5_to_q",    q,           32'h0000_FB02);
        chk("t5_to_rd",   32'(mem_rd), 32'h0);
      end
`else
      chk("t5_rd",   32'(mem_rd), 32'h1);
      chk("t5_err",  32'(err),    32'h0);
      chk("t5_done", 32'(done),   32'h0);
`endif
    end
    tick();
`ifndef TIMEOUT_EN
    chk("t5_hold", 32'(mem_rd), 32'h1);
`endif
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // clr in the middle of a request beats a simultaneous ack
    rd_start = 1'b1; addr = 9'h1AB;
    tick();
    chk("t4_rd", 32'(mem_rd), 32'h1);
    rd_start = 1'b0; clr = 1'b1; mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    chk("t4_rd0",   32'(mem_rd), 32'h0);
    chk("t4_busy",  32'(busy),   32'h0);
    chk("t4_q",     q,           32'h0);
    chk("t4_done",  32'(done),   32'h0);
    clr = 1'b0; mem_ack = 1'b0;
    tick();
    chk("t4_nodone", 32'(done), 32'h0);

    // Back-to-back reads with rd_start held: done every third cycle
    rd_start = 1'b1; mem_ack = 1'b1; addr = 9'h033; mem_data = 32'hA5A5_0001;
    dn = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (done) dn++;
      chk("t6_pat", 32'(done), (i % 3 == 1) ? 32'h1 : 32'h0);
    end
    chk("t6_cnt", 32'(dn), 32'd3);
    rd_start = 1'b0; mem_ack = 1'b0;
    tick(); tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clr      = ($urandom_range(0, 63) == 0);
      rd_start = 1'($urandom_range(0, 1));
      addr     = AW'($urandom_range(0, 511));
      mem_ack  = ($urandom_range(0, 3) == 0);
      mem_data = $urandom;
      tick();
    end
    clr = 1'b0; rd_start = 1'b0; mem_ack = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
